icache_mem_responder: RTL and testbench
=======================================

# icache_mem_responder

Memory-side responder for instruction-cache line fills. It accepts a single miss request from the cache control logic and models backing-memory access latency. It then reads one cache line word by word from a synchronous-read backing memory and returns the words to the cache as a valid/ready burst, pulsing a completion flag on the last beat. It sits between the instruction cache's memory interface and the backing instruction memory.

## Interface
Parameters:
- ADDR_WIDTH, 16: word-address width.
- WORD_WIDTH, 32: data word width.
- WORDS_PER_LINE, 4: words per cache line; power of two, ≥2.
- MEM_LATENCY, 3: cycles from request acceptance to first memory read; ≥1.

Ports:
- clk  in  1  rising-edge clock.
- arst_n  in  1  asynchronous, active-low reset.
- i_halt  in  1  freezes all state while high.
- i_req_valid  in  1  fill request from cache.
- i_req_addr  in  ADDR_WIDTH  word address of the missed word.
- o_req_ready  out  1  request can be accepted.
- o_rd_en  out  1  backing-memory read strobe.
- o_rd_addr  out  ADDR_WIDTH  backing-memory read address.
- i_rd_data  in  WORD_WIDTH  read data, valid the cycle after o_rd_en; held by memory until the next o_rd_en.
- o_data_valid  out  1  beat valid.
- o_data  out  WORD_WIDTH  beat data.
- o_word_offset  out  log2(WORDS_PER_LINE)  line offset of the current beat.
- i_data_ready  in  1  cache accepts beat.
- o_data_received  out  1  high with the last beat of the line.
- o_busy  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: waiting for a request.
  - WAIT: latency counter running.
  - FETCH: first read issued.
  - BEAT: presenting a word.
- Acceptance is `i_req_valid & o_req_ready` at a clock edge.
  - `o_req_ready = (state==IDLE) & ~i_halt`, combinational.
  - On acceptance, the responder latches line base = i_req_addr with the low log2(WORDS_PER_LINE) bits cleared.
  - It latches the start offset (see Configuration).
  - The latency counter loads MEM_LATENCY-1.
- IDLE→WAIT on acceptance.
- WAIT: the counter decrements each non-halted cycle. WAIT→FETCH when the counter is 0.
- FETCH: o_rd_en=1 with o_rd_addr = base + offset. FETCH→BEAT.
- BEAT:
  - The o_data register captures i_rd_data in the cycle after each o_rd_en.
  - o_data_valid is high from that cycle.
  - A beat completes on `o_data_valid & i_data_ready & ~i_halt`.
  - On beat completion, if it is not the last beat: the offset increments modulo WORDS_PER_LINE, o_rd_en is asserted in that same cycle for the next address, and the next beat is valid the following cycle.
  - On the last beat: o_data_received=1 together with o_data_valid, and BEAT→IDLE.
- The offset counter wraps modulo WORDS_PER_LINE. The address is always base + offset; there is no carry into the tag bits.
- Requests arriving while busy are ignored. The cache keeps i_req_valid high until accepted.
- Halt freezes state, counters, o_data and o_data_valid. While halted, o_rd_en is forced to 0 and no beat completes.

## Timing
- Reset values: IDLE, o_rd_en=0, o_rd_addr=0, o_data_valid=0, o_data=0, o_word_offset=0, o_data_received=0, o_busy=0.
- Reset is asynchronous. Assertion mid-burst aborts immediately and discards the partial line.
- Accept at edge T:
  - o_busy rises after T.
  - o_rd_en is high in cycle T+MEM_LATENCY.
  - The first beat is valid in cycle T+MEM_LATENCY+1.
- With i_data_ready held high and no halt:
  - Beats occur in consecutive cycles T+L+1 … T+L+WORDS_PER_LINE.
  - o_data_received is high in the last of those cycles.
  - o_req_ready is high again the next cycle.
- Backpressure: o_data and o_word_offset remain stable while o_data_valid=1 and i_data_ready=0. No read is reissued.
- Each halted cycle delays every subsequent event by exactly one cycle.

## Configuration
- CRITICAL_WORD_FIRST_EN defined: the start offset is the low bits of i_req_addr. The burst begins at the missed word and wraps.
- CRITICAL_WORD_FIRST_EN undefined: the start offset is always 0. The burst is returned in ascending order.
- The beat count is WORDS_PER_LINE in both cases.

## Test plan
- All scenarios use WORDS_PER_LINE=4 and MEM_LATENCY=3. Memory word at address A = A ^ 0xA5A50000.
- Accept 0x0012 at T, ready high, macro defined → o_rd_en at T+3. Beats T+4..T+7 with offsets 2,3,0,1 and data for 0x12,0x13,0x10,0x11. o_data_received only at T+7.
- Same stimulus, macro undefined → offsets 0,1,2,3; addresses 0x10..0x13.
- Drop i_data_ready for 2 cycles on beat 2 → o_data and o_word_offset held for 3 cycles, one extra o_rd_en never seen. Last beat at T+9.
- i_halt high for 2 cycles during WAIT → o_rd_en at T+5, first beat at T+6, o_req_ready=0 throughout.
- Second i_req_valid raised during the burst → ignored; it is accepted on the cycle o_req_ready returns and produces a full, correct second line.
- arst_n pulsed low during beat 3 → all outputs 0 immediately. A new request afterwards returns a full, correct line.

Source files
------------

// File: rtl/icache_mem_responder.sv
// Instruction-cache line-fill responder: latency wait, then a valid/ready burst of one line.
// Optional macro CRITICAL_WORD_FIRST_EN starts the burst at the missed word and wraps.
module icache_mem_responder #(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int MEM_LATENCY    = 3
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              i_halt,
    input  logic                              i_req_valid,
    input  logic [ADDR_WIDTH-1:0]             i_req_addr,
    output logic                              o_req_ready,
    output logic                              o_rd_en,
    output logic [ADDR_WIDTH-1:0]             o_rd_addr,
    input  logic [WORD_WIDTH-1:0]             i_rd_data,
    output logic                              o_data_valid,
    output logic [WORD_WIDTH-1:0]             o_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] o_word_offset,
    input  logic                              i_data_ready,
    output logic                              o_data_received,
    output logic                              o_busy
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_BEAT
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [OFF_W-1:0]      r_offset;
    logic [OFF_W-1:0]      r_beat_cnt;
    logic                  r_data_valid;
    logic                  r_pending;
    logic [WORD_WIDTH-1:0] r_data;

    logic                  w_accept;
    logic                  w_beat_done;
    logic                  w_last;
    logic [OFF_W-1:0]      w_next_off;
    logic [OFF_W-1:0]      w_rd_off;
    logic [OFF_W-1:0]      w_start_off;

`ifdef CRITICAL_WORD_FIRST_EN
    assign w_start_off = i_req_addr[OFF_W-1:0];
`else
    assign w_start_off = '0;
`endif

    assign w_accept    = i_req_valid & o_req_ready;
    assign w_last      = (r_beat_cnt == OFF_W'(WORDS_PER_LINE - 1));
    assign w_beat_done = (r_state == S_BEAT) & r_data_valid & i_data_ready & ~i_halt;
    assign w_next_off  = r_offset + 1'b1;
    assign w_rd_off    = (r_state == S_BEAT) ? w_next_off : r_offset;

    assign o_req_ready     = (r_state == S_IDLE) & ~i_halt;
    assign o_rd_en         = ~i_halt & ((r_state == S_FETCH) | (w_beat_done & ~w_last));
    assign o_rd_addr       = r_base | ADDR_WIDTH'(w_rd_off);
    assign o_data_valid    = r_data_valid;
    assign o_word_offset   = r_offset;
    assign o_data_received = r_data_valid & w_last;
    assign o_busy          = (r_state != S_IDLE);

    // Read data is passed straight through in the cycle after a read and held
    // in r_data afterwards, so a beat is valid one cycle after its o_rd_en.
    assign o_data = r_pending ? i_rd_data : r_data;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_base       <= '0;
            r_offset     <= '0;
            r_beat_cnt   <= '0;
            r_data_valid <= 1'b0;
            r_pending    <= 1'b0;
            r_data       <= '0;
        end else if (!i_halt) begin
            r_pending <= o_rd_en;
            if (r_pending) begin
                r_data <= i_rd_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_base     <= i_req_addr & ~ADDR_WIDTH'(WORDS_PER_LINE - 1);
                        r_offset   <= w_start_off;
                        r_beat_cnt <= '0;
                        r_cnt      <= CNT_W'(MEM_LATENCY - 1);
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_FETCH: begin
                    r_data_valid <= 1'b1;
                    r_state      <= S_BEAT;
                end
                S_BEAT: begin
                    if (w_beat_done) begin
                        if (w_last) begin
                            r_data_valid <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_offset   <= w_next_off;
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_mem_responder.sv
// Scoreboard bench for icache_mem_responder: directed timing cases plus randomized traffic.
// Expected beats follow the CRITICAL_WORD_FIRST_EN setting of the build.
module tb_icache_mem_responder;

    localparam int AW   = 16;
    localparam int WW   = 32;
    localparam int WPL  = 4;
    localparam int LAT  = 3;
    localparam logic [31:0] MASK = 32'hA5A50000;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          i_halt = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic          o_req_ready;
    logic          o_rd_en;
    logic [AW-1:0] o_rd_addr;
    logic [WW-1:0] i_rd_data = '0;
    logic          o_data_valid;
    logic [WW-1:0] o_data;
    logic [1:0]    o_word_offset;
    logic          i_data_ready = 1'b0;
    logic          o_data_received;
    logic          o_busy;

    icache_mem_responder #(
        .ADDR_WIDTH(AW),
        .WORD_WIDTH(WW),
        .WORDS_PER_LINE(WPL),
        .MEM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .arst_n(arst_n),
        .i_halt(i_halt),
        .i_req_valid(i_req_valid),
        .i_req_addr(i_req_addr),
        .o_req_ready(o_req_ready),
        .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr),
        .i_rd_data(i_rd_data),
        .o_data_valid(o_data_valid),
        .o_data(o_data),
        .o_word_offset(o_word_offset),
        .i_data_ready(i_data_ready),
        .o_data_received(o_data_received),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read backing memory: word at A is A ^ MASK, held until next read.
    always @(posedge clk) if (o_rd_en) i_rd_data <= 32'(o_rd_addr) ^ MASK;

    typedef struct {
        logic [31:0] data;
        int          off;
        bit          last;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   vecs = 0;
    int   errs = 0;
    bit   noise = 1'b0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard on every completed beat.
    int          rdcnt = 0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic [1:0]  prev_off = '0;
    always @(negedge clk) begin
        if (!arst_n) begin
            sb.delete();
            rdcnt     = 0;
            prev_hold = 1'b0;
        end else begin
            exp_t e;
            if (o_rd_en) rdcnt++;
            if (i_halt) check("rd_en_during_halt", 64'(o_rd_en), 64'd0);
            if (prev_hold) begin
                check("hold_data", 64'(o_data), 64'(prev_data));
                check("hold_offset", 64'(o_word_offset), 64'(prev_off));
            end
            prev_hold = o_data_valid & ~(i_data_ready & ~i_halt);
            prev_data = o_data;
            prev_off  = o_word_offset;
            if (o_data_valid && i_data_ready && !i_halt) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", 64'(o_data), 64'(e.data));
                    check("beat_offset", 64'(o_word_offset), 64'(e.off));
                    check("beat_last", 64'(o_data_received), 64'(e.last));
                    if (e.cyc >= 0) check("beat_cycle", 64'(cyc), 64'(e.cyc));
                    if (e.last) begin
                        check("reads_per_line", 64'(rdcnt), 64'(WPL));
                        rdcnt = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (noise) begin
            i_data_ready = ($urandom_range(0, 3) != 0);
            i_halt       = ($urandom_range(0, 9) == 0);
        end
    endtask

    // Raise a request, wait for acceptance, push the line's expected beats.
    // Beats k >= dfrom are expected dly cycles later than an unstalled burst.
    task automatic send(input logic [AW-1:0] a, input bit timed, input int dfrom, input int dly,
                        output int t);
        bit ok = 1'b0;
        bit acc;
        i_req_valid = 1'b1;
        i_req_addr  = a;
        t = -1;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            acc = o_req_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                t  = cyc;
            end
        end
        i_req_valid = 1'b0;
        if (!ok) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            int start = CWF ? int'(a % WPL) : 0;
            for (int k = 0; k < WPL; k++) begin
                exp_t e;
                int off = (start + k) % WPL;
                logic [AW-1:0] la = (a & ~16'(WPL - 1)) | 16'(off);
                e.data = 32'(la) ^ MASK;
                e.off  = off;
                e.last = (k == WPL - 1);
                e.cyc  = timed ? (t + LAT + 1 + k + ((k >= dfrom) ? dly : 0)) : -1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            tick();
            if (sb.size() == 0 && !o_busy) done = 1'b1;
        end
        if (!done) check("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic tick_to(input int c);
        for (int n = 0; n < 200 && cyc < c; n++) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"}, 64'(o_rd_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(o_rd_addr), 64'd0);
        check({tag, "_data_valid"}, 64'(o_data_valid), 64'd0);
        check({tag, "_data"}, 64'(o_data), 64'd0);
        check({tag, "_word_offset"}, 64'(o_word_offset), 64'd0);
        check({tag, "_data_received"}, 64'(o_data_received), 64'd0);
        check({tag, "_busy"}, 64'(o_busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2;
        logic [AW-1:0] base_exp;

        // Reset values
        #12;
        check_zero_outputs("reset");
        tick();
        arst_n = 1'b1;
        tick();
        check("ready_after_reset", 64'(o_req_ready), 64'd1);
        i_data_ready = 1'b1;

        // Clean line: latency and back-to-back beats
        send(16'h0012, 1'b1, WPL, 0, t);
        check("busy_after_accept", 64'(o_busy), 64'd1);
        check("ready_low_busy", 64'(o_req_ready), 64'd0);
        tick_to(t + 2);
        check("rd_en_before_latency", 64'(o_rd_en), 64'd0);
        tick_to(t + 3);
        check("rd_en_at_latency", 64'(o_rd_en), 64'd1);
        base_exp = CWF ? 16'h0012 : 16'h0010;
        check("first_rd_addr", 64'(o_rd_addr), 64'(base_exp));
        wait_idle();
        check("ready_return_cycle", 64'(cyc), 64'(t + 8));
        check("ready_returned", 64'(o_req_ready), 64'd1);

        // Backpressure on the second beat for two cycles
        send(16'h1237, 1'b1, 1, 2, t);
        tick_to(t + 5);
        i_data_ready = 1'b0;
        tick_to(t + 7);
        i_data_ready = 1'b1;
        wait_idle();

        // Halt for two cycles during the latency wait
        send(16'h0BE1, 1'b1, 0, 2, t);
        tick_to(t + 1);
        i_halt = 1'b1;
        check("ready_low_halt1", 64'(o_req_ready), 64'd0);
        tick_to(t + 2);
        check("ready_low_halt2", 64'(o_req_ready), 64'd0);
        tick_to(t + 3);
        i_halt = 1'b0;
        check("ready_low_after_halt", 64'(o_req_ready), 64'd0);
        tick_to(t + 4);
        check("rd_en_halt_delayed", 64'(o_rd_en), 64'd0);
        tick_to(t + 5);
        check("rd_en_after_halt", 64'(o_rd_en), 64'd1);
        wait_idle();

        // Request raised mid-burst is held off until ready returns
        send(16'h4442, 1'b1, WPL, 0, t);
        tick_to(t + 5);
        send(16'h7FFD, 1'b1, WPL, 0, t2);
        check("second_accept_cycle", 64'(t2), 64'(t + 9));
        wait_idle();

        // Asynchronous reset during the third beat
        send(16'h2223, 1'b1, WPL, 0, t);
        tick_to(t + 6);
        arst_n = 1'b0;
        #1;
        check_zero_outputs("midburst_reset");
        tick();
        arst_n = 1'b1;
        tick();
        send(16'h00C6, 1'b1, WPL, 0, t);
        wait_idle();

        // Randomized traffic with backpressure and halts
        noise = 1'b1;
        for (int n = 0; n < 40; n++) begin
            send(16'($urandom), 1'b0, WPL, 0, t);
            if ($urandom_range(0, 2) == 0) wait_idle();
        end
        noise = 1'b0;
        i_halt = 1'b0;
        i_data_ready = 1'b1;
        wait_idle();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
